// File: rtl/cfa_grad_window_pkg.sv
// Shared types and default sizes for the CFA gradient window slice.
package cfa_grad_window_pkg;

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam int DEF_PIX_W        = 12;
    localparam int DEF_LINE_WIDTH   = 640;
    localparam int DEF_FRAME_HEIGHT = 480;
    localparam int FILL_ROWS        = 4;

endpackage

// File: rtl/cfa_grad_window_if.sv
// Pixel-in / column-out stream bundle for cfa_grad_window.
// With CFA_WIN_SOF_EN defined the bundle also carries the sof flag.
interface cfa_grad_window_if
    import cfa_grad_window_pkg::*;
#(
    parameter int pixelBitWidth = DEF_PIX_W
);
    logic [pixelBitWidth-1:0] pix_in;
    logic                     pix_valid;
    logic                     pix_ready;
    logic [pixelBitWidth-1:0] e1;
    logic [pixelBitWidth-1:0] e2;
    logic [pixelBitWidth-1:0] e3;
    logic [pixelBitWidth-1:0] e4;
    logic [pixelBitWidth-1:0] e5;
    logic [pixelBitWidth-1:0] mean_1;
    logic                     out_valid;
    logic                     out_ready;
    logic                     eof;
`ifdef CFA_WIN_SOF_EN
    logic                     sof;

    // slave: the window block; master: pixel source plus column consumer
    modport slave (
        input  pix_in, pix_valid, out_ready, sof,
        output pix_ready, e1, e2, e3, e4, e5, mean_1, out_valid, eof
    );
    modport master (
        output pix_in, pix_valid, out_ready, sof,
        input  pix_ready, e1, e2, e3, e4, e5, mean_1, out_valid, eof
    );
`else
    modport slave (
        input  pix_in, pix_valid, out_ready,
        output pix_ready, e1, e2, e3, e4, e5, mean_1, out_valid, eof
    );
    modport master (
        output pix_in, pix_valid, out_ready,
        input  pix_ready, e1, e2, e3, e4, e5, mean_1, out_valid, eof
    );
`endif
endinterface

// File: rtl/cfa_grad_window_line_buffer.sv
// One line of pixel storage: combinational read, synchronous write, no reset.
module cfa_grad_window_line_buffer
    import cfa_grad_window_pkg::*;
#(
    parameter int pixelBitWidth = DEF_PIX_W,
    parameter int LINE_WIDTH    = DEF_LINE_WIDTH,
    parameter int COL_W         = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [COL_W-1:0]         addr,
    input  logic [pixelBitWidth-1:0] wdata,
    output logic [pixelBitWidth-1:0] rdata
);

    logic [pixelBitWidth-1:0] mem [LINE_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cfa_grad_window.sv
// Buffers four Bayer lines and emits one vertical 5-tap column plus mean_1 per accepted pixel.
// Optional CFA_WIN_SOF_EN adds an sof input that realigns the frame to (0,0).
//
//   state     | meaning
//   ST_FILL   | rows 0..3 of a frame: pixels only prime the line buffers
//   ST_STREAM | rows 4..end: every accepted pixel produces an output column
module cfa_grad_window
    import cfa_grad_window_pkg::*;
#(
    parameter int pixelBitWidth = DEF_PIX_W,
    parameter int LINE_WIDTH    = DEF_LINE_WIDTH,
    parameter int FRAME_HEIGHT  = DEF_FRAME_HEIGHT,
    parameter int COL_W         = 10,
    parameter int ROW_W         = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    cfa_grad_window_if.slave       bus
);

    localparam logic [COL_W-1:0]         COL_LAST      = COL_W'(LINE_WIDTH - 1);
    localparam logic [ROW_W-1:0]         ROW_LAST      = ROW_W'(FRAME_HEIGHT - 1);
    localparam logic [ROW_W-1:0]         ROW_FILL_LAST = ROW_W'(FILL_ROWS - 1);
    localparam logic [COL_W-1:0]         COL_ONE       = COL_W'(1);
    localparam logic [ROW_W-1:0]         ROW_ONE       = ROW_W'(1);
    localparam logic [pixelBitWidth:0]   MEAN_RND      = (pixelBitWidth+1)'(1);

    logic [COL_W-1:0]         col_q, col_eff;
    logic [ROW_W-1:0]         row_q, row_eff;
    state_t                   state_q, state_eff, state_d;
    logic                     accept, sof_acc;
    logic                     col_last, row_last;
    logic                     load_out, eof_d;
    logic [pixelBitWidth-1:0] lb_rd [FILL_ROWS];
    logic [pixelBitWidth-1:0] lb_wd [FILL_ROWS];

    assign bus.pix_ready = !bus.out_valid | bus.out_ready;
    assign accept        = bus.pix_valid & bus.pix_ready;

`ifdef CFA_WIN_SOF_EN
    assign sof_acc = accept & bus.sof;
`else
    assign sof_acc = 1'b0;
`endif

    // An sof pixel is handled as if the counters and FSM were already at frame origin.
    assign col_eff   = sof_acc ? '0 : col_q;
    assign row_eff   = sof_acc ? '0 : row_q;
    assign state_eff = sof_acc ? ST_FILL : state_q;
    assign col_last  = (col_eff == COL_LAST);
    assign row_last  = (row_eff == ROW_LAST);

    assign lb_wd[0] = bus.pix_in;

    for (genvar i = 0; i < FILL_ROWS; i++) begin : g_lb
        if (i > 0) begin : g_shift
            assign lb_wd[i] = lb_rd[i-1];
        end
        cfa_grad_window_line_buffer #(
            .pixelBitWidth (pixelBitWidth),
            .LINE_WIDTH    (LINE_WIDTH),
            .COL_W         (COL_W)
        ) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (col_eff),
            .wdata (lb_wd[i]),
            .rdata (lb_rd[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_eff + ROW_ONE;
            end else begin
                col_q <= col_eff + COL_ONE;
                row_q <= row_eff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = state_eff;
            case (state_eff)
                ST_FILL:   if (row_eff == ROW_FILL_LAST && col_last) state_d = ST_STREAM;
                ST_STREAM: if (row_last && col_last)                 state_d = ST_FILL;
                default:   state_d = ST_FILL;
            endcase
        end
    end

    always_comb begin
        load_out = accept && (state_eff == ST_STREAM);
        eof_d    = row_last && col_last;
    end

    // lb_rd[3] is the oldest row (r-4), lb_rd[0] the previous row (r-1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.eof       <= 1'b0;
            bus.e1        <= '0;
            bus.e2        <= '0;
            bus.e3        <= '0;
            bus.e4        <= '0;
            bus.e5        <= '0;
            bus.mean_1    <= '0;
        end else if (load_out) begin
            bus.out_valid <= 1'b1;
            bus.eof       <= eof_d;
            bus.e1        <= lb_rd[3];
            bus.e2        <= lb_rd[2];
            bus.e3        <= lb_rd[1];
            bus.e4        <= lb_rd[0];
            bus.e5        <= bus.pix_in;
            bus.mean_1    <= pixelBitWidth'(({1'b0, lb_rd[2]} + {1'b0, lb_rd[0]} + MEAN_RND) >> 1);
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.eof       <= 1'b0;
        end
    end

endmodule
